// File: rtl/gpio_system.sv
// gpio_system: UART 8N1 host link, byte-command parser, small register file
// driving an 8-bit bidirectional GPIO port and a status LED.
module gpio_system #(
  parameter int clk_freq       = 50_000_000,
  parameter int uart_baud_rate = 115200
) (
  input  logic       clk,
  input  logic       rst,
  output logic       led,
  input  logic       uart_rxd,
  output logic       uart_txd,
  inout  wire  [7:0] gpio0_io
);

  localparam int CLKS_PER_BIT = clk_freq / uart_baud_rate;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_WAIT_DATA, P_SEND} p_state_t;

  rx_state_t        rx_state, rx_next;
  tx_state_t        tx_state, tx_next;
  p_state_t         p_state, p_next;

  logic             rxd_meta, rxd_sync, rxd_prev;
  logic [7:0]       gpio_meta, gpio_in;
  logic [CNT_W-1:0] rx_cnt, tx_cnt;
  logic [2:0]       rx_bit, tx_bit;
  logic [7:0]       rx_shift, rx_hold, tx_shift;
  logic             rx_done, rx_full, rx_take;
  logic             tx_load, tx_busy;
  logic             reg_we;
  logic [3:0]       cmd_addr;
  logic [7:0]       reply, rd_data;
  logic [7:0]       gpio_out, gpio_oe;
  logic             led_reg;

  // Bring the asynchronous UART line and GPIO pins into the clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rxd_prev  <= 1'b1;
      gpio_meta <= '0;
      gpio_in   <= '0;
    end else begin
      rxd_meta  <= uart_rxd;
      rxd_sync  <= rxd_meta;
      rxd_prev  <= rxd_sync;
      gpio_meta <= gpio0_io;
      gpio_in   <= gpio_meta;
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // Receiver sequencing: start recheck at half bit, then bit-centre samples
  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rxd_prev && !rxd_sync) rx_next = RX_START;
      RX_START: if (rx_cnt == HALF_LAST) rx_next = rxd_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_cnt == BIT_LAST) begin
                  rx_next = RX_IDLE;
                  rx_done = rxd_sync;
                end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Receiver bit timer and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_next != rx_state || rx_cnt == BIT_LAST)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) begin
        rx_bit <= '0;
      end else if (rx_state == RX_DATA && rx_cnt == BIT_LAST) begin
        rx_shift <= {rxd_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  // One-deep holding register; a new byte overwrites an unread one
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_full <= 1'b0;
      rx_hold <= '0;
    end else if (rx_done) begin
      rx_full <= 1'b1;
      rx_hold <= rx_shift;
    end else if (rx_take) begin
      rx_full <= 1'b0;
    end
  end

  // Transmitter state register
  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  // Transmitter sequencing through start, eight data bits and stop
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_load) tx_next = TX_START;
      TX_START: if (tx_cnt == BIT_LAST) tx_next = TX_DATA;
      TX_DATA:  if (tx_cnt == BIT_LAST && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_cnt == BIT_LAST) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // Transmitter bit timer and shift register, loaded only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      if (tx_state == TX_IDLE || tx_cnt == BIT_LAST)
        tx_cnt <= '0;
      else
        tx_cnt <= tx_cnt + 1'b1;
      if (tx_state == TX_IDLE && tx_load) begin
        tx_shift <= reply;
        tx_bit   <= '0;
      end else if (tx_state == TX_DATA && tx_cnt == BIT_LAST) begin
        tx_shift <= {1'b1, tx_shift[7:1]};
        tx_bit   <= tx_bit + 1'b1;
      end
    end
  end

  assign tx_busy = (tx_state != TX_IDLE);

  // Line level follows the transmitter state; idle and stop are high
  always_comb begin
    case (tx_state)
      TX_START: uart_txd = 1'b0;
      TX_DATA:  uart_txd = tx_shift[0];
      default:  uart_txd = 1'b1;
    endcase
  end

  // Parser state register
  always_ff @(posedge clk) begin
    if (rst) p_state <= P_IDLE;
    else     p_state <= p_next;
  end

  // Parser: consume command (and data for writes), then queue one reply
  always_comb begin
    p_next  = p_state;
    rx_take = 1'b0;
    reg_we  = 1'b0;
    tx_load = 1'b0;
    case (p_state)
      P_IDLE: if (rx_full) begin
        rx_take = 1'b1;
        p_next  = (rx_hold[7:4] == 4'h1) ? P_WAIT_DATA : P_SEND;
      end
      P_WAIT_DATA: if (rx_full) begin
        rx_take = 1'b1;
        reg_we  = 1'b1;
        p_next  = P_SEND;
      end
      P_SEND: if (!tx_busy) begin
        tx_load = 1'b1;
        p_next  = P_IDLE;
      end
      default: p_next = P_IDLE;
    endcase
  end

  // Register read mux addressed by the pending command byte
  always_comb begin
    case (rx_hold[3:0])
      4'd0:    rd_data = gpio_out;
      4'd1:    rd_data = gpio_oe;
      4'd2:    rd_data = gpio_in;
      4'd3:    rd_data = {7'b0, led_reg};
      default: rd_data = 8'h00;
    endcase
  end

  // Latch the address and the reply (read data snapshot, ACK or NAK)
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_addr <= '0;
      reply    <= '0;
    end else if (p_state == P_IDLE && rx_full) begin
      cmd_addr <= rx_hold[3:0];
      case (rx_hold[7:4])
        4'h1:    reply <= 8'h06;
        4'h2:    reply <= rd_data;
        default: reply <= 8'h15;
      endcase
    end
  end

  // Writable registers; read-only and unmapped addresses ignore writes
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out <= '0;
      gpio_oe  <= '0;
      led_reg  <= 1'b0;
    end else if (reg_we) begin
      case (cmd_addr)
        4'd0:    gpio_out <= rx_hold;
        4'd1:    gpio_oe  <= rx_hold;
        4'd3:    led_reg  <= rx_hold[0];
        default: ;
      endcase
    end
  end

  assign led = led_reg;

  for (genvar i = 0; i < 8; i++) begin : g_pin
    assign gpio0_io[i] = gpio_oe[i] ? gpio_out[i] : 1'bz;
  end

endmodule

// File: tb/tb_gpio_system.sv
// tb_gpio_system: drives UART commands at 43 clk/bit, decodes replies from
// uart_txd and compares them with a register-level model of the GPIO block.
module tb_gpio_system;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 1_152_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int LAT_MAX  = CPB / 2 + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  wire        uart_txd;
  wire        led;
  wire  [7:0] gpio_pins;
  logic [7:0] tb_en  = 8'hFF;
  logic [7:0] tb_val = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stop_begin = 0;
  int last_start = 0;

  logic [7:0] m_out = 8'h00;
  logic [7:0] m_oe  = 8'h00;
  logic       m_led = 1'b0;

  logic [7:0] reply_q[$];
  int         start_q[$];

  for (genvar i = 0; i < 8; i++) begin : g_drv
    assign gpio_pins[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  gpio_system #(.clk_freq(CLK_FREQ), .uart_baud_rate(BAUD)) dut (
    .clk      (clk),
    .rst      (rst),
    .led      (led),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .gpio0_io (gpio_pins)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Decode every frame seen on uart_txd into the reply queue
  initial begin : tx_monitor
    logic [7:0] b;
    int t0;
    b = '0;
    forever begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        if (uart_txd === 1'b0) begin
          for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clk);
            b[k] = uart_txd;
          end
          repeat (CPB) @(negedge clk);
          reply_q.push_back(b);
          start_q.push_back(t0);
        end
      end
    end
  end

  // Hard stop if anything hangs
  initial begin
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [3:0] a);
    case (a)
      4'd0:    return m_out;
      4'd1:    return m_oe;
      4'd2:    return (m_out & m_oe) | (tb_val & ~m_oe);
      4'd3:    return {7'b0, m_led};
      default: return 8'h00;
    endcase
  endfunction

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      uart_rxd = b[k];
      repeat (CPB) @(negedge clk);
    end
    stop_begin = cyc;
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_reply(input string tag, input logic [7:0] exp);
    int budget;
    logic [7:0] got;
    budget = 30 * CPB;
    while (reply_q.size() == 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    assert (reply_q.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s got=timeout expected=%0h", tag, exp);
    end
    if (reply_q.size() != 0) begin
      got = reply_q.pop_front();
      last_start = start_q.pop_front();
      check_output(tag, got, exp);
    end
  endtask

  task automatic apply_write(input logic [3:0] a, input logic [7:0] d);
    if (a == 4'd1) tb_en = ~m_oe & ~d;
    uart_send({4'h1, a}, 1'b1);
    uart_send(d, 1'b1);
    case (a)
      4'd0:    m_out = d;
      4'd1:    m_oe  = d;
      4'd3:    m_led = d[0];
      default: ;
    endcase
    wait_reply("write_ack", 8'h06);
    tb_en = ~m_oe;
    check_output("led_pin", led, m_led);
    check_output("gpio_pins_driven", gpio_pins & m_oe, m_out & m_oe);
  endtask

  task automatic apply_read(input logic [3:0] a);
    logic [7:0] exp;
    exp = model_read(a);
    uart_send({4'h2, a}, 1'b1);
    wait_reply("read_reply", exp);
  endtask

  task automatic flush_replies();
    repeat (12 * CPB) @(negedge clk);
    reply_q.delete();
    start_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic [3:0] a;
    logic [3:0] op;
    int lows;

    // Reset for four clocks and then check the idle line
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_output("reset_txd", uart_txd, 1'b1);
    check_output("reset_led", led, 1'b0);
    rst = 1'b0;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check_output("idle_after_reset", lows, 0);
    apply_read(4'd1);
    apply_read(4'd0);

    // LED write and readback, plus reply latency
    apply_write(4'd3, 8'h01);
    apply_read(4'd3);
    checks++;
    assert ((last_start - stop_begin <= LAT_MAX) === 1'b1) else begin
      errors++;
      $error("[TB] FAIL reply_latency got=%0d expected<=%0d", last_start - stop_begin, LAT_MAX);
    end

    // Drive the port as outputs
    apply_write(4'd1, 8'hFF);
    apply_write(4'd0, 8'hA5);
    check_output("pins_A5", gpio_pins, 8'hA5);
    apply_read(4'd0);

    // Port as inputs: bench drives 0x3C
    apply_write(4'd1, 8'h00);
    tb_val = 8'h3C;
    repeat (4) @(negedge clk);
    apply_read(4'd2);
    apply_read(4'hF);

    // Unknown opcode, then a frame with a bad stop bit
    uart_send(8'h55, 1'b1);
    wait_reply("nak", 8'h15);
    uart_send(8'h21, 1'b0);
    repeat (15 * CPB) @(negedge clk);
    check_output("framing_no_reply", reply_q.size(), 0);
    repeat (CPB) @(negedge clk);
    apply_read(4'd3);

    // Randomised mix of writes, reads and unknown opcodes
    for (int n = 0; n < 12; n++) begin
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0: apply_write(a, d);
        1: begin
          tb_val = 8'($urandom);
          repeat (4) @(negedge clk);
          apply_read(a);
        end
        default: begin
          op = 4'($urandom_range(0, 15));
          if (op == 4'h1 || op == 4'h2) op = 4'h7;
          uart_send({op, a}, 1'b1);
          wait_reply("rand_nak", 8'h15);
        end
      endcase
    end

    // Reset in the middle of a reply
    apply_write(4'd3, 8'h01);
    apply_write(4'd1, 8'hFF);
    apply_write(4'd0, 8'h5A);
    uart_send(8'h20, 1'b1);
    lows = 0;
    while (uart_txd === 1'b1 && lows < 30 * CPB) begin
      @(negedge clk);
      lows++;
    end
    check_output("reply_started", uart_txd, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midreply_txd", uart_txd, 1'b1);
    check_output("midreply_led", led, 1'b0);
    rst = 1'b0;
    m_out = 8'h00;
    m_oe  = 8'h00;
    m_led = 1'b0;
    tb_en = 8'hFF;
    flush_replies();
    apply_read(4'd1);
    apply_read(4'd0);

    // Reset while the parser waits for a write data byte
    apply_write(4'd3, 8'h01);
    uart_send(8'h13, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_output("midwrite_led", led, 1'b0);
    rst = 1'b0;
    m_led = 1'b0;
    flush_replies();
    uart_send(8'h01, 1'b1);
    wait_reply("parser_idle_nak", 8'h15);
    apply_read(4'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
